// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and dump state type for the register file
//
// Purpose: bus widths, zero constants, enable encodings and the dump engine
//          state type used by regfile and regfile_dump.
// Ports:   none (package).
package regfile_pkg;

  localparam int DataBus    = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  localparam logic [DataBus-1:0]    ZeroData     = '0;
  localparam logic [RegAddrBus-1:0] ZeroDataAddr = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  typedef enum logic [0:0] {
    DumpIdle = 1'b0,
    DumpSend = 1'b1
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - dump engine FSM walking every register index once
//
// Purpose: on a request in IDLE, presents indices 0..2^IDX_W-1 one per accepted
//          beat, holding the index under backpressure.
// Ports:   i_clk, i_rst      clock, async active-high reset
//          i_req            start request (sampled in IDLE only)
//          i_ready          consumer accepts the current beat
//          o_valid, o_busy  beat presented / engine not idle
//          o_idx            index of the current beat
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int IDX_W = RegNumLog2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [IDX_W-1:0] LastIdx = {IDX_W{1'b1}};

  dump_state_t      r_state;
  dump_state_t      w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= DumpIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    o_valid     = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      DumpIdle: begin
        if (i_req) begin
          w_state_nxt = DumpSend;
          w_idx_nxt   = '0;
        end
      end
      DumpSend: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready) begin
          if (r_idx == LastIdx) begin
            w_state_nxt = DumpIdle;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = DumpIdle;
      end
    endcase
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file with bypassed read ports and debug dump
//
// Purpose: writeback-stage register file. r0 reads zero; two combinational
//          read ports with same-cycle write bypass; a handshaked dump stream
//          reads every register through a third bypassed read path.
// Ports:   clk, rst                  clock, async active-high reset
//          we, waddr, wdata          writeback port
//          re1/raddr1/rdata1         read port 1
//          re2/raddr2/rdata2         read port 2
//          dump_req                  start a full dump
//          dump_valid/dump_ready     dump beat handshake
//          dump_addr/dump_data       dump beat payload
//          dump_busy                 dump engine active
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM      = RegNum,
  parameter int REG_NUM_LOG2 = RegNumLog2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_NUM_LOG2-1:0] waddr,
  input  logic [DataBus-1:0]      wdata,
  input  logic                    re1,
  input  logic [REG_NUM_LOG2-1:0] raddr1,
  output logic [DataBus-1:0]      rdata1,
  input  logic                    re2,
  input  logic [REG_NUM_LOG2-1:0] raddr2,
  output logic [DataBus-1:0]      rdata2,
  input  logic                    dump_req,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [REG_NUM_LOG2-1:0] dump_addr,
  output logic [DataBus-1:0]      dump_data,
  output logic                    dump_busy
);

  logic [DataBus-1:0]      r_regs [REG_NUM];
  logic                    w_dump_valid;
  logic                    w_dump_busy;
  logic [REG_NUM_LOG2-1:0] w_dump_idx;
  logic                    w_hit1;
  logic                    w_hit2;
  logic                    w_hit_d;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= ZeroData;
      end
    end else if (we == WriteEnable && waddr != ZeroDataAddr) begin
      r_regs[waddr] <= wdata;
    end
  end

  // A write to r0 can never hit here because address 0 is forced to zero first.
  assign w_hit1  = (we == WriteEnable) && (waddr == raddr1);
  assign w_hit2  = (we == WriteEnable) && (waddr == raddr2);
  assign w_hit_d = (we == WriteEnable) && (waddr == w_dump_idx);

  assign rdata1 = (re1 != ReadEnable || raddr1 == ZeroDataAddr) ? ZeroData :
                  (w_hit1 ? wdata : r_regs[raddr1]);
  assign rdata2 = (re2 != ReadEnable || raddr2 == ZeroDataAddr) ? ZeroData :
                  (w_hit2 ? wdata : r_regs[raddr2]);

  regfile_dump #(
    .IDX_W (REG_NUM_LOG2)
  ) u_dump (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (dump_req),
    .i_ready (dump_ready),
    .o_valid (w_dump_valid),
    .o_busy  (w_dump_busy),
    .o_idx   (w_dump_idx)
  );

  // The dump path is a third read port with an implicit enable, gated to zero
  // whenever no beat is presented so reset and idle leave the bus quiet.
  assign dump_valid = w_dump_valid;
  assign dump_busy  = w_dump_busy;
  assign dump_addr  = w_dump_valid ? w_dump_idx : ZeroDataAddr;
  assign dump_data  = (!w_dump_valid || w_dump_idx == ZeroDataAddr) ? ZeroData :
                      (w_hit_d ? wdata : r_regs[w_dump_idx]);

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized and directed self-checking bench for regfile
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        dump_req;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural register contents plus dump progress.
  logic [31:0] model [32];
  bit          m_dumping;
  int          m_next;

  logic [4:0]  obs_addr;
  logic [31:0] obs_data;
  logic        obs_valid;

  always #5 clk = ~clk;

  regfile dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .re2        (re2),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    m_dumping = 0;
    m_next    = 0;
  endtask

  task automatic idle_inputs();
    we = 0; waddr = 0; wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    dump_req = 0; dump_ready = 0;
  endtask

  // One clock cycle: check every output at the falling edge, then advance the
  // model with the inputs that were present at the rising edge.
  task automatic cyc();
    @(negedge clk);
    check_eq("rdata1", rdata1, exp_read(re1, raddr1));
    check_eq("rdata2", rdata2, exp_read(re2, raddr2));
    check_eq("dump_valid", {31'h0, dump_valid}, {31'h0, m_dumping});
    check_eq("dump_busy", {31'h0, dump_busy}, {31'h0, m_dumping});
    if (m_dumping) begin
      check_eq("dump_addr", {27'h0, dump_addr}, m_next);
      check_eq("dump_data", dump_data, exp_read(1'b1, 5'(m_next)));
    end
    obs_addr  = dump_addr;
    obs_data  = dump_data;
    obs_valid = dump_valid;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_dumping) begin
        if (dump_ready) begin
          if (m_next == 31) m_dumping = 0;
          else m_next++;
        end
      end else if (dump_req) begin
        m_dumping = 1;
        m_next    = 0;
      end
      if (we && waddr != 0) model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic start_dump();
    dump_req = 1;
    cyc();
    dump_req = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    re1 = 1; raddr1 = 5'd3; re2 = 1; raddr2 = 5'd31;
    #3;
    check_eq("reset_rdata1", rdata1, 32'h0);
    check_eq("reset_rdata2", rdata2, 32'h0);
    check_eq("reset_valid", {31'h0, dump_valid}, 32'h0);
    check_eq("reset_busy", {31'h0, dump_busy}, 32'h0);
    check_eq("reset_daddr", {27'h0, dump_addr}, 32'h0);
    check_eq("reset_ddata", dump_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;

    // Write r7, read it back next cycle; write r0, reads stay zero.
    idle_inputs();
    we = 1; waddr = 5'd7; wdata = 32'hDEADBEEF;
    cyc();
    idle_inputs();
    re1 = 1; raddr1 = 5'd7;
    cyc();
    check_eq("r7_read", obs_valid ? 32'hX : 32'h0, 32'h0);
    @(negedge clk);
    check_eq("r7_rdata1", rdata1, 32'hDEADBEEF);
    @(posedge clk); #1;
    we = 1; waddr = 5'd0; wdata = 32'h12345678;
    re1 = 1; raddr1 = 5'd0; re2 = 1; raddr2 = 5'd0;
    cyc();
    we = 0;
    @(negedge clk);
    check_eq("r0_rdata1", rdata1, 32'h0);
    check_eq("r0_rdata2", rdata2, 32'h0);
    @(posedge clk); #1;

    // Bypass on both ports, then with port 2 disabled.
    we = 1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
    re1 = 1; raddr1 = 5'd9; re2 = 1; raddr2 = 5'd9;
    @(negedge clk);
    check_eq("byp_rdata1", rdata1, 32'hA5A5A5A5);
    check_eq("byp_rdata2", rdata2, 32'hA5A5A5A5);
    re2 = 0;
    #1;
    check_eq("byp_re2_off", rdata2, 32'h0);
    re2 = 1;
    @(posedge clk);
    model[9] = 32'hA5A5A5A5;
    #1;

    // Randomized traffic with concurrent dumps and random backpressure.
    for (int n = 0; n < 400; n++) begin
      we     = ($urandom_range(0, 2) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 4) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      re2    = ($urandom_range(0, 4) != 0);
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      dump_req   = ($urandom_range(0, 19) == 0);
      dump_ready = ($urandom_range(0, 1) == 1);
      cyc();
    end

    // Drain any dump still in progress.
    idle_inputs();
    dump_ready = 1;
    for (int n = 0; n < 40 && m_dumping; n++) cyc();
    check_eq("drain_done", {31'h0, dump_busy}, 32'h0);
    dump_ready = 0;

    // Preload r1..r31 and run a full dump with ready held high.
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = (i << 8) + i;
      cyc();
    end
    idle_inputs();
    start_dump();
    dump_ready = 1;
    for (int i = 0; i < 32; i++) begin
      cyc();
      check_eq("full_valid", {31'h0, obs_valid}, 32'h1);
      check_eq("full_addr", {27'h0, obs_addr}, i);
      check_eq("full_data", obs_data, (i == 0) ? 32'h0 : ((i << 8) + i));
    end
    cyc();
    check_eq("full_end_valid", {31'h0, obs_valid}, 32'h0);
    check_eq("full_end_busy", {31'h0, dump_busy}, 32'h0);

    // Backpressure at idx 12 with a concurrent write in the second stall cycle.
    start_dump();
    dump_ready = 1;
    for (int i = 0; i < 12; i++) cyc();
    dump_ready = 0;
    cyc();
    check_eq("stall1_addr", {27'h0, obs_addr}, 32'd12);
    check_eq("stall1_data", obs_data, 32'h00000C0C);
    we = 1; waddr = 5'd12; wdata = 32'h0BADF00D;
    cyc();
    check_eq("stall2_addr", {27'h0, obs_addr}, 32'd12);
    check_eq("stall2_data", obs_data, 32'h0BADF00D);
    we = 0;
    cyc();
    check_eq("stall3_addr", {27'h0, obs_addr}, 32'd12);
    check_eq("stall3_data", obs_data, 32'h0BADF00D);
    dump_ready = 1;
    cyc();
    check_eq("accept12_addr", {27'h0, obs_addr}, 32'd12);
    cyc();
    check_eq("after12_addr", {27'h0, obs_addr}, 32'd13);
    for (int n = 0; n < 40 && m_dumping; n++) cyc();
    check_eq("bp_done", {31'h0, dump_busy}, 32'h0);

    // Reset in the middle of a dump at idx 20.
    start_dump();
    dump_ready = 1;
    for (int i = 0; i < 20; i++) cyc();
    re1 = 1; raddr1 = 5'd5;
    @(negedge clk);
    check_eq("pre_rst_addr", {27'h0, dump_addr}, 32'd20);
    #2;
    rst = 1;
    #1;
    check_eq("rst_valid", {31'h0, dump_valid}, 32'h0);
    check_eq("rst_busy", {31'h0, dump_busy}, 32'h0);
    check_eq("rst_daddr", {27'h0, dump_addr}, 32'h0);
    check_eq("rst_ddata", dump_data, 32'h0);
    check_eq("rst_rdata1", rdata1, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("post_rst_r5", rdata1, 32'h0);
    check_eq("post_rst_idle", {31'h0, obs_valid}, 32'h0);
    start_dump();
    cyc();
    check_eq("restart_valid", {31'h0, obs_valid}, 32'h1);
    check_eq("restart_addr", {27'h0, obs_addr}, 32'd0);
    for (int n = 0; n < 40 && m_dumping; n++) cyc();
    check_eq("restart_done", {31'h0, dump_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file at the writeback end of the five-stage pipeline. It consumes the registered writeback triple (`wb_wdata`, `wb_waddr`, `wb_we`) from the MEM/WB pipeline register and serves two combinational operand-read ports to the decode stage. A same-cycle write-to-read bypass removes the writeback/decode hazard. A handshaked debug dump engine streams all 32 registers to the debug unit while the pipeline keeps running.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers; fixed at 32 for this core.
- `REG_NUM_LOG2`, 5: register index width; must equal the `RegAddrBus` width.

Ports (`DataBus` = 32 bits, `RegAddrBus` = 5 bits):
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  1  write enable; driven by `wb_we`.
- `waddr`  in  5  write index; driven by `wb_waddr`.
- `wdata`  in  32  write data; driven by `wb_wdata`.
- `re1`  in  1  read port 1 enable.
- `raddr1`  in  5  read port 1 index.
- `rdata1`  out  32  read port 1 data; combinational.
- `re2`  in  1  read port 2 enable.
- `raddr2`  in  5  read port 2 index.
- `rdata2`  out  32  read port 2 data; combinational.
- `dump_req`  in  1  starts a full-register dump; sampled only in the IDLE state.
- `dump_valid`  out  1  a dump beat is presented.
- `dump_ready`  in  1  the debug unit accepts the current beat.
- `dump_addr`  out  5  index of the current beat.
- `dump_data`  out  32  value of the current beat.
- `dump_busy`  out  1  high while the dump engine is not in IDLE.

## Operation
Storage and writes:
- Storage is 32 × 32-bit registers. Register 0 is hardwired to zero.
- A write takes effect at the rising edge of `clk` when `we=1` and `waddr≠0`. A write with `waddr=0` is discarded.

Read ports (1 and 2, identical and independent):
- `rdataN = 0` when `reN=0` or `raddrN=0`.
- Otherwise, when `we=1` and `waddr==raddrN`, `rdataN = wdata` (bypass).
- Otherwise, `rdataN` is the stored value of register `raddrN`.
- Both ports may address the same register and may both be bypassed in the same cycle.

Dump engine, states IDLE and SEND, 5-bit index `idx`:
- IDLE: `dump_valid=0`, `dump_busy=0`. If `dump_req=1`, then `idx←0` and the next state is SEND.
- SEND: `dump_valid=1`, `dump_busy=1`, `dump_addr=idx`. `dump_data` follows the read-port rules with an implicit enable of 1 and address `idx`, so register 0 reads 0 and a same-cycle write to `idx` is bypassed.
- A transfer occurs when `dump_valid & dump_ready`. On a transfer with `idx<31`, `idx←idx+1`. On a transfer with `idx=31`, the next state is IDLE.
- With `dump_ready=0`, `dump_addr` holds. `dump_data` may change only if a write to `idx` lands; the beat always shows the live value.
- `dump_req` is ignored while in SEND and is not queued.
- Pipeline writes and reads proceed normally during a dump.

## Timing
- Reads: zero latency (combinational from addresses, enables and the write port).
- Writes: visible through storage in the cycle after the write edge, and in the write cycle itself through the bypass.
- Dump: first beat is valid one cycle after `dump_req` is sampled in IDLE. With `dump_ready` held high, a dump takes exactly 32 cycles in SEND. `dump_busy` falls in the cycle after the beat for register 31 is accepted.
- Reset, asynchronous and effective immediately:
  - all registers become 0 and the state becomes IDLE with `idx=0`;
  - `dump_valid`, `dump_busy`, `dump_addr` and `dump_data` become 0;
  - `rdata1` and `rdata2` read 0 unless a bypass is active.
- Reset mid-dump aborts the dump with no further beats. A new `dump_req` is honoured on the first clock edge after `rst` deasserts.
- Simultaneous `dump_req` and `rst`: reset wins.

## Structure
- Constants come from the shared `defines.v` package: `DataBus`, `RegAddrBus`, `ZeroData`, `ZeroDataAddr`, `WriteEnable`/`WriteDisable`, `ReadEnable`/`ReadDisable`.
- New constants to add to `defines.v`: `RegNum` (32), `RegNumLog2` (5), and dump state encodings `DumpIdle`/`DumpSend`.
- One sub-module is natural: `regfile_dump`, holding the FSM and `idx`. It drives the dump address into a third internal read path of `regfile`.

## Test plan
- **Reset:** assert `rst` mid-cycle with registers holding data → all outputs 0 immediately. Read r5 after release → 0.
- **Write/read:** write r7=0xDEADBEEF → next cycle `rdata1` (r7) = 0xDEADBEEF. Write r0=0x12345678 → r0 reads 0 on both ports.
- **Bypass:** `we=1`, `waddr=9`, `wdata=0xA5A5A5A5`, `raddr1=raddr2=9`, both enables high → both ports show 0xA5A5A5A5 in that cycle. Same stimulus with `re2=0` → `rdata2=0`.
- **Full dump:** preload r1..r31 with value (i<<8)+i, pulse `dump_req`, hold `dump_ready=1` → 32 beats over 32 cycles, addr 0..31, data 0 then (i<<8)+i. `dump_busy` drops after the last beat.
- **Backpressure and concurrent write:** during a dump, drop `dump_ready` at idx=12 for 3 cycles and write r12=0x0BADF00D in the second stall cycle → `dump_addr` holds at 12, `dump_data` changes to 0x0BADF00D, and the beat is accepted when `dump_ready` returns.
- **Reset mid-dump:** assert `rst` at idx=20 → `dump_valid=0` immediately, no further beats. A `dump_req` after release restarts the dump at idx=0.
